seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a bank of `DIGITS` seven-segment displays sharing one segment bus. It holds a double-buffered hex value and cycles a one-hot digit enable at a programmable refresh rate. For each digit it presents that digit's decoded pattern: 0-F in GFEDCBA order, plus decimal point and per-digit blanking. It sits between datapath results and the board display pins, and replaces one-decoder-per-digit wiring.

---
 rtl/seven_segment_pkg.sv | 39 +++
 rtl/seven_segment_decode.sv | 34 +++
 rtl/seven_segment_scanner.sv | 135 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scanner: GFEDCBA segment patterns and
// the leading-zero blank helper used when SEVENSEG_LZ_BLANK_EN is defined.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b1111100;
    localparam logic [6:0] SEG_C   = 7'b1011000;
    localparam logic [6:0] SEG_D   = 7'b1011110;
    localparam logic [6:0] SEG_E   = 7'b1111001;
    localparam logic [6:0] SEG_F   = 7'b1110001;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Bit i (i > 0) is set when nibble i and every higher nibble are zero.
    // Digit 0 is never auto-blanked so an all-zero value still shows "0".
    function automatic logic [7:0] lz_blank(input logic [31:0] data, input int digits);
        logic [7:0] v;
        logic       zero_above;
        v          = '0;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < digits) begin
                zero_above = zero_above && (data[i*4 +: 4] == 4'h0);
                v[i]       = zero_above;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational hex-to-segment decoder, active-high GFEDCBA, with blank override.
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (nibble)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver with a double-buffered display value.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  load,
    output logic [6:0]            sevenseg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int               TW        = $clog2(REFRESH_DIV);
    localparam int               IDXW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(DIGITS - 1);
    localparam logic             INV       = (ACTIVE_LOW != 0);

    logic [TW-1:0]          tick;
    logic [IDXW-1:0]        idx;
    logic                   slot_end;
    logic                   wrap;

    logic [4*DIGITS-1:0]    shadow_data;
    logic [DIGITS-1:0]      shadow_dp;
    logic [DIGITS-1:0]      shadow_mask;
    logic                   pending;

    logic [4*DIGITS-1:0]    active_data;
    logic [DIGITS-1:0]      active_dp;
    logic [DIGITS-1:0]      active_blank;

    logic [4*DIGITS-1:0]    wr_data;
    logic [DIGITS-1:0]      wr_dp;
    logic [DIGITS-1:0]      wr_mask;
    logic [DIGITS-1:0]      wr_blank;
    logic                   bypass;

    logic [3:0]             cur_nibble;
    logic                   cur_blank;
    logic [6:0]             seg_dec;
    logic [DIGITS-1:0]      onehot;

    assign slot_end = (tick == TICK_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);
    assign bypass   = load && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
        end else begin
            tick <= slot_end ? '0 : tick + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load on the wrap cycle goes straight to the active buffer.
    always_comb begin
        wr_data = bypass ? data_in    : shadow_data;
        wr_dp   = bypass ? dp_in      : shadow_dp;
        wr_mask = bypass ? blank_mask : shadow_mask;
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    logic [7:0] lz_vec;
    assign lz_vec   = lz_blank(32'(wr_data), DIGITS);
    assign wr_blank = wr_mask | lz_vec[DIGITS-1:0];
`else
    assign wr_blank = wr_mask;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_mask  <= '0;
            pending      <= 1'b0;
            active_data  <= '0;
            active_dp    <= '0;
            active_blank <= '0;
        end else begin
            if (load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
                shadow_mask <= blank_mask;
            end
            if (wrap && (load || pending)) begin
                active_data  <= wr_data;
                active_dp    <= wr_dp;
                active_blank <= wr_blank;
                pending      <= 1'b0;
            end else if (load) begin
                pending      <= 1'b1;
            end
        end
    end

    assign cur_nibble = active_data[{idx, 2'b00} +: 4];
    assign cur_blank  = active_blank[idx];
    assign onehot     = DIGITS'(1) << idx;

    seven_segment_decode u_decode (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (seg_dec)
    );

    // Polarity is applied only here so the internal datapath stays active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sevenseg   <= {7{INV}};
            dp         <= INV;
            digit_en   <= {DIGITS{INV}};
            frame_done <= 1'b0;
        end else begin
            sevenseg   <= seg_dec ^ {7{INV}};
            dp         <= (active_dp[idx] & ~cur_blank) ^ INV;
            digit_en   <= onehot ^ {DIGITS{INV}};
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench: DIGITS=4, REFRESH_DIV=4, one active-high and one active-low
// instance sharing inputs; expected display tracked per output cycle.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        load;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  en_h, en_l;
    logic        fd_h, fd_l;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;

    logic [15:0] disp_data,  q_data;
    logic [3:0]  disp_dp,    q_dp;
    logic [3:0]  disp_blank, q_blank;
    logic        qv;

    always #5 clk = ~clk;

    seven_segment_scanner #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .blank_mask(blank_mask), .load(load),
        .sevenseg(seg_h), .dp(dp_h), .digit_en(en_h), .frame_done(fd_h)
    );

    seven_segment_scanner #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .blank_mask(blank_mask), .load(load),
        .sevenseg(seg_l), .dp(dp_l), .digit_en(en_l), .frame_done(fd_l)
    );

    function automatic logic [6:0] seg_tab(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b1011000;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Digit i > 0 auto-blanks when the value shifted down to it is zero.
    function automatic logic [3:0] lz_exp(input logic [15:0] d);
        logic [3:0] b;
        b = 4'b0000;
`ifdef SEVENSEG_LZ_BLANK_EN
        for (int i = 1; i < 4; i++) b[i] = ((d >> (4*i)) == 16'h0000);
`endif
        return b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic step_check();
        int         d;
        logic       bl;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_en;
        logic       e_fd;
        @(posedge clk);
        n++;
        if (n > 1 && ((n - 1) % 16) == 0 && qv) begin
            disp_data  = q_data;
            disp_dp    = q_dp;
            disp_blank = q_blank;
            qv         = 1'b0;
        end
        if (load) begin
            q_data  = data_in;
            q_dp    = dp_in;
            q_blank = blank_mask | lz_exp(data_in);
            qv      = 1'b1;
        end
        @(negedge clk);
        d     = ((n - 1) / 4) % 4;
        bl    = disp_blank[d];
        e_seg = bl ? 7'b0000000 : seg_tab(disp_data[d*4 +: 4]);
        e_dp  = disp_dp[d] & ~bl;
        e_en  = 4'b0001 << d;
        e_fd  = ((n % 16) == 0);
        chk("seg_h", {1'b0, seg_h}, {1'b0, e_seg});
        chk("dp_h",  {7'b0, dp_h},  {7'b0, e_dp});
        chk("en_h",  {4'b0, en_h},  {4'b0, e_en});
        chk("fd_h",  {7'b0, fd_h},  {7'b0, e_fd});
        chk("seg_l", {1'b0, seg_l}, {1'b0, ~e_seg});
        chk("dp_l",  {7'b0, dp_l},  {7'b0, ~e_dp});
        chk("en_l",  {4'b0, en_l},  {4'b0, ~e_en});
        chk("fd_l",  {7'b0, fd_l},  {7'b0, e_fd});
    endtask

    task automatic run_to(input int target);
        while (n < target) step_check();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data_in    = d;
        dp_in      = p;
        blank_mask = b;
        load       = 1'b1;
        step_check();
        load       = 1'b0;
    endtask

    task automatic model_reset();
        n          = 0;
        disp_data  = '0;
        disp_dp    = '0;
        disp_blank = '0;
        q_data     = '0;
        q_dp       = '0;
        q_blank    = '0;
        qv         = 1'b0;
    endtask

    task automatic chk_inactive(input string tag);
        chk({tag, "_seg_h"}, {1'b0, seg_h}, 8'h00);
        chk({tag, "_dp_h"},  {7'b0, dp_h},  8'h00);
        chk({tag, "_en_h"},  {4'b0, en_h},  8'h00);
        chk({tag, "_fd_h"},  {7'b0, fd_h},  8'h00);
        chk({tag, "_seg_l"}, {1'b0, seg_l}, 8'h7F);
        chk({tag, "_dp_l"},  {7'b0, dp_l},  8'h01);
        chk({tag, "_en_l"},  {4'b0, en_l},  8'h0F);
        chk({tag, "_fd_l"},  {7'b0, fd_l},  8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed n=%0d required completion", n);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        data_in    = '0;
        dp_in      = '0;
        blank_mask = '0;
        load       = 1'b0;
        model_reset();
        @(negedge clk);
        chk_inactive("rst");
        @(negedge clk);
        reset = 1'b0;

        // frame of zeros, scan order and frame_done cadence
        run_to(16);

        // mid-frame load waits for the wrap
        run_to(22);
        do_load(16'h12AF, 4'b0000, 4'b0000);
        run_to(48);

        // two loads in one frame: newest wins
        run_to(52);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run_to(56);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run_to(80);

        // load exactly on the wrap cycle
        run_to(95);
        do_load(16'h3456, 4'b0000, 4'b0000);
        run_to(112);

        // blank mask on digit 2, decimal point on digit 0
        run_to(116);
        do_load(16'h8888, 4'b0001, 4'b0100);
        run_to(144);

        // leading zeros
        run_to(148);
        do_load(16'h0050, 4'b0000, 4'b0000);
        run_to(176);
        run_to(180);
        do_load(16'h0000, 4'b0000, 4'b0000);
        run_to(208);

        // nonzero active, then a pending load cut off by reset in slot 2
        do_load(16'hE0D1, 4'b1010, 4'b0000);
        run_to(226);
        do_load(16'h7777, 4'b1111, 4'b0000);
        run_to(234);
        reset = 1'b1;
        #1;
        chk_inactive("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_to(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
